l1_win_ctrl: RTL and testbench

Sequencer for the 13x13 layer-1 feature-map RAM (169 words, 18 bit, one synchronous write port, one read port with one-cycle latency). The controller first fills the RAM from an upstream valid/ready stream in raster order. It then scans every 3x3 window (stride 1, 11x11 windows) and streams the nine taps of each window to the downstream MAC with valid/ready backpressure. It owns all RAM address, write-enable and write-data pins.

---
 rtl/l1_win_ctrl.sv | 133 +++++++++++++
 tb/tb_l1_win_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/l1_win_ctrl.sv
// l1_win_ctrl: fills the 13x13 feature-map RAM from a stream, then streams every 3x3 window's taps
module l1_win_ctrl #(
  parameter int W  = 13,
  parameter int K  = 3,
  parameter int DW = 18,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr_wr,
  output logic [DW-1:0] ram_din,
  output logic [AW-1:0] ram_addr_rd,
  input  logic [DW-1:0] ram_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_tap,
  output logic          out_last_tap,
  output logic          out_last_win
);
  localparam int N  = W * W;
  localparam int RW = $clog2(W);
  localparam int KW = $clog2(K);
  typedef enum logic [1:0] {IDLE, FILL, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] fill_cnt, base, off, addr, nxt;
  logic [RW-1:0] r, c;
  logic [KW-1:0] i, j;
  logic [3:0] tap, tap_r;
  logic iss, rd_pend, lt_r, lw_r;
  logic adv, issue, last_acc, wr, last_wr;
  assign in_ready = state == FILL;
  assign wr       = in_valid && in_ready;
  assign last_wr  = wr && fill_cnt == AW'(N - 1);
  assign adv      = !rd_pend || out_ready;
  assign issue    = state == SCAN && iss && adv;
  assign last_acc = state == SCAN && rd_pend && out_ready && !iss;
  assign nxt      = base + off;
  // On a stall the held address is re-presented so the RAM keeps returning the same word.
  assign ram_addr_rd  = issue ? nxt : addr;
  assign busy         = state == FILL || state == SCAN;
  assign done         = state == DONE;
  assign ram_wr       = wr;
  assign ram_addr_wr  = fill_cnt;
  assign ram_din      = in_ready ? in_data : '0;
  assign out_valid    = rd_pend;
  assign out_data     = ram_dout;
  assign out_tap      = tap_r;
  assign out_last_tap = lt_r;
  assign out_last_win = lw_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && start) ? FILL :
               last_wr                  ? SCAN :
               last_acc                 ? DONE :
               state == DONE            ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
      base     <= '0;
      off      <= '0;
      addr     <= '0;
      r        <= '0;
      c        <= '0;
      i        <= '0;
      j        <= '0;
      tap      <= '0;
      tap_r    <= '0;
      iss      <= 1'b0;
      rd_pend  <= 1'b0;
      lt_r     <= 1'b0;
      lw_r     <= 1'b0;
    end else begin
      if (wr) fill_cnt <= last_wr ? '0 : fill_cnt + 1'b1;
      if (last_wr) begin
        base <= '0;
        off  <= '0;
        r    <= '0;
        c    <= '0;
        i    <= '0;
        j    <= '0;
        tap  <= '0;
        iss  <= 1'b1;
      end else if (issue) begin
        addr    <= nxt;
        tap_r   <= tap;
        lt_r    <= tap == 4'(K * K - 1);
        lw_r    <= r == RW'(W - K) && c == RW'(W - K);
        rd_pend <= 1'b1;
        if (j != KW'(K - 1)) begin
          j   <= j + 1'b1;
          off <= off + 1'b1;
          tap <= tap + 1'b1;
        end else if (i != KW'(K - 1)) begin
          j   <= '0;
          i   <= i + 1'b1;
          off <= off + AW'(W - K + 1);
          tap <= tap + 1'b1;
        end else begin
          i   <= '0;
          j   <= '0;
          off <= '0;
          tap <= '0;
          if (c != RW'(W - K)) begin
            c    <= c + 1'b1;
            base <= base + 1'b1;
          end else if (r != RW'(W - K)) begin
            c    <= '0;
            r    <= r + 1'b1;
            base <= base + AW'(K);
          end else iss <= 1'b0;
        end
      end else if (last_acc) rd_pend <= 1'b0;
      if (state == DONE) begin
        addr  <= '0;
        tap_r <= '0;
        lt_r  <= 1'b0;
        lw_r  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_l1_win_ctrl.sv
// tb_l1_win_ctrl: fill/scan checks against a window-enumeration model with a behavioural RAM
module tb_l1_win_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [17:0] in_data = '0, ram_din, ram_dout, out_data;
  logic [7:0] ram_addr_wr, ram_addr_rd;
  logic busy, done, in_ready, ram_wr, out_valid, out_last_tap, out_last_win;
  logic [3:0] out_tap;
  logic [17:0] mem [0:255];
  logic [17:0] ref_pix [0:168];
  int checks = 0, errors = 0;
  wire [44:0] outs = {busy, done, in_ready, ram_wr, out_valid, out_tap, out_last_tap,
                      out_last_win, ram_addr_wr, ram_addr_rd, ram_din};

  l1_win_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_wr(ram_wr), .ram_addr_wr(ram_addr_wr), .ram_din(ram_din),
    .ram_addr_rd(ram_addr_rd), .ram_dout(ram_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tap(out_tap), .out_last_tap(out_last_tap), .out_last_win(out_last_win)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr_wr] <= ram_din;
    ram_dout <= mem[ram_addr_rd];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int pct);
    return pct >= 100 ? 1'b1 : ($urandom_range(0, 99) < pct);
  endfunction

  task automatic fill(input bit gaps, input bit rnd);
    int n = 0, cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
    while (n < 169 && cyc < 3000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = rnd ? 18'($urandom) : 18'(n);
      start    = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      chk("fill_in_ready", in_ready, 1);
      chk("fill_wr", ram_wr, in_valid);
      if (in_valid) begin
        chk("fill_addr", ram_addr_wr, n);
        chk("fill_din", ram_din, in_data);
        ref_pix[n] = in_data;
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("fill_count", n, 169);
    start = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("scan0_in_ready", in_ready, 0);
    chk("scan0_wr", ram_wr, 0);
    chk("scan0_busy", busy, 1);
    chk("scan0_addr_rd", ram_addr_rd, 0);
    chk("scan0_valid", out_valid, 0);
    in_valid = 1'b0;
  endtask

  task automatic scan(input int pct, input int abort_at);
    logic [17:0] exp_q[$];
    logic [17:0] hd;
    logic [3:0] ht;
    int k = 0, cyc = 0;
    bit stalled = 0;
    for (int r = 0; r <= 10; r++)
      for (int c = 0; c <= 10; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_q.push_back(ref_pix[(r + i) * 13 + c + j]);
    out_ready = rdy(pct);
    @(negedge clk);
    while (k < 1089 && cyc < 20000) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_zero", outs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", outs, 0);
        return;
      end
      chk("valid", out_valid, 1);
      chk("data", out_data, exp_q[k]);
      chk("tap", out_tap, k % 9);
      chk("last_tap", out_last_tap, k % 9 == 8);
      chk("last_win", out_last_win, k >= 1080);
      if (stalled) begin
        chk("hold_data", out_data, hd);
        chk("hold_tap", out_tap, ht);
      end
      out_ready = rdy(pct);
      stalled = !out_ready;
      hd = out_data;
      ht = out_tap;
      if (out_ready) k++;
      cyc++;
      @(negedge clk);
    end
    chk("tap_count", k, 1089);
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", out_valid, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 18'h2a;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      chk("idle_zero", outs, 0);
    end
    in_valid = 1'b0;
    fill(0, 0);
    scan(100, -1);
    fill(1, 1);
    scan(50, -1);
    fill(0, 1);
    scan(100, 500);
    fill(1, 1);
    scan(100, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
